// File: rtl/prime_trial_sequencer.sv
// Trial-division primality sequencer. Takes one candidate N, issues N mod d
// requests to an external is-zero divider for d = 2, 3, 5, 7, ... while
// d*d <= N, and reports primality plus the smallest factor found.
module prime_trial_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  // candidate in
  input  logic             i_cand_valid,
  output logic             o_cand_ready,
  input  logic [WIDTH-1:0] i_cand_n,
  // verdict out
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic             o_res_prime,
  output logic [WIDTH-1:0] o_res_factor,
  // divider request
  output logic             o_div_valid,
  input  logic             i_div_ready,
  output logic [WIDTH-1:0] o_div_a,
  output logic [WIDTH-1:0] o_div_b,
  // divider response
  input  logic             i_div_y,
  input  logic             i_div_done,
  output logic             o_div_ack
);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StIssue,
    StWait,
    StDone
  } state_e;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_n, w_n_next;
  logic [WIDTH-1:0] r_d, w_d_next;
  logic             r_prime, w_prime_next;
  logic [WIDTH-1:0] r_factor, w_factor_next;

  // d*d at double width so the loop bound never wraps
  logic [2*WIDTH-1:0] w_dd;
  logic [2*WIDTH-1:0] w_n_ext;
  logic               w_n_small;
  logic               w_d_past_root;

  assign w_dd          = {{WIDTH{1'b0}}, r_d} * {{WIDTH{1'b0}}, r_d};
  assign w_n_ext       = {{WIDTH{1'b0}}, r_n};
  assign w_n_small     = (r_n < WIDTH'(2));
  assign w_d_past_root = (w_dd > w_n_ext);

  // State and datapath registers; reset clears everything to idle values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_n      <= '0;
      r_d      <= '0;
      r_prime  <= 1'b0;
      r_factor <= '0;
    end else begin
      r_state  <= w_state_next;
      r_n      <= w_n_next;
      r_d      <= w_d_next;
      r_prime  <= w_prime_next;
      r_factor <= w_factor_next;
    end
  end

  // Next-state and datapath update; verdict registers change only on a decision.
  always_comb begin
    w_state_next  = r_state;
    w_n_next      = r_n;
    w_d_next      = r_d;
    w_prime_next  = r_prime;
    w_factor_next = r_factor;
    case (r_state)
      StIdle: begin
        if (i_cand_valid) begin
          w_n_next     = i_cand_n;
          w_d_next     = WIDTH'(2);
          w_state_next = StCheck;
        end
      end
      StCheck: begin
        if (w_n_small) begin
          w_prime_next  = 1'b0;
          w_factor_next = '0;
          w_state_next  = StDone;
        end else if (w_d_past_root) begin
          w_prime_next  = 1'b1;
          w_factor_next = '0;
          w_state_next  = StDone;
        end else begin
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        if (i_div_ready) begin
          w_state_next = StWait;
        end
      end
      StWait: begin
        if (i_div_done) begin
          if (i_div_y) begin
            w_prime_next  = 1'b0;
            w_factor_next = r_d;
            w_state_next  = StDone;
          end else begin
            // after 2 only odd divisors are worth trying
            w_d_next     = (r_d == WIDTH'(2)) ? WIDTH'(3) : r_d + WIDTH'(2);
            w_state_next = StCheck;
          end
        end
      end
      StDone: begin
        if (i_res_ready) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Handshake outputs decode the registered state only.
  assign o_cand_ready = (r_state == StIdle);
  assign o_res_valid  = (r_state == StDone);
  assign o_div_valid  = (r_state == StIssue);
  assign o_div_ack    = (r_state == StWait);
  assign o_res_prime  = r_prime;
  assign o_res_factor = r_factor;
  assign o_div_a      = r_n;
  assign o_div_b      = r_d;

endmodule

// File: tb/tb_prime_trial_sequencer.sv
// Bench for prime_trial_sequencer: a 32-bit instance driven by a stalling,
// noisy divider model, and an 8-bit instance with an always-ready divider.
module tb_prime_trial_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;

  // 32-bit instance signals
  logic        cand_valid = 1'b0;
  logic        cand_ready;
  logic [31:0] cand_n = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        res_prime;
  logic [31:0] res_factor;
  logic        div_valid;
  logic        div_ready = 1'b0;
  logic [31:0] div_a, div_b;
  logic        div_y = 1'b0;
  logic        div_done = 1'b0;
  logic        div_ack;

  // 8-bit instance signals
  logic       cand8_valid = 1'b0;
  logic       cand8_ready;
  logic [7:0] cand8_n = '0;
  logic       res8_valid;
  logic       res8_ready = 1'b0;
  logic       res8_prime;
  logic [7:0] res8_factor;
  logic       div8_valid;
  logic       div8_ready = 1'b0;
  logic [7:0] div8_a, div8_b;
  logic       div8_y = 1'b0;
  logic       div8_done = 1'b0;
  logic       div8_ack;

  prime_trial_sequencer #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cand_valid(cand_valid), .o_cand_ready(cand_ready), .i_cand_n(cand_n),
    .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_prime(res_prime),
    .o_res_factor(res_factor),
    .o_div_valid(div_valid), .i_div_ready(div_ready), .o_div_a(div_a), .o_div_b(div_b),
    .i_div_y(div_y), .i_div_done(div_done), .o_div_ack(div_ack)
  );

  prime_trial_sequencer #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cand_valid(cand8_valid), .o_cand_ready(cand8_ready), .i_cand_n(cand8_n),
    .o_res_valid(res8_valid), .i_res_ready(res8_ready), .o_res_prime(res8_prime),
    .o_res_factor(res8_factor),
    .o_div_valid(div8_valid), .i_div_ready(div8_ready), .o_div_a(div8_a), .o_div_b(div8_b),
    .i_div_y(div8_y), .i_div_done(div8_done), .o_div_ack(div8_ack)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  // ---------------- 32-bit divider model (runs on negedge) ----------------
  bit          stall_en = 0;
  bit          noise_en = 0;
  bit          m_busy = 0;
  int          m_cnt = 0;
  bit          m_y = 0;
  logic [31:0] bq[$];
  int          vcnt = 0;
  int          stab_err = 0;
  bit          p_valid = 0;
  logic [31:0] p_a = '0, p_b = '0;

  always @(negedge clk) begin
    if (div_valid) begin
      vcnt++;
      if (p_valid && (div_a !== p_a || div_b !== p_b)) stab_err++;
    end
    p_valid = div_valid;
    p_a     = div_a;
    p_b     = div_b;
    if (!rst_n) begin
      m_busy    = 0;
      div_ready = 1'b0;
      div_done  = 1'b0;
      div_y     = 1'b0;
    end else if (!m_busy) begin
      div_ready = (stall_en && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      // spurious results while no request is outstanding must be ignored
      div_done  = noise_en && ($urandom_range(0, 3) == 0);
      div_y     = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      if (div_valid && div_ready) begin
        m_busy = 1;
        m_cnt  = stall_en ? int'($urandom_range(0, 3)) : 0;
        m_y    = (div_b != 0) && (div_a % div_b == 0);
        bq.push_back(div_b);
      end
    end else begin
      div_ready = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        div_done = 1'b0;
        div_y    = 1'($urandom_range(0, 1));
      end else begin
        div_done = 1'b1;
        div_y    = m_y;
        if (div_ack) m_busy = 0;
      end
    end
  end

  // ---------------- 8-bit divider model: always ready, one-cycle result ----
  logic [7:0] bq8[$];
  always @(negedge clk) begin
    div8_ready = 1'b1;
    div8_done  = div8_ack;
    div8_y     = (div8_b != 0) && (div8_a % div8_b == 0);
    if (div8_valid) bq8.push_back(div8_b);
  end

  // ---------------- run helpers ----------------
  logic        g_prime;
  logic [31:0] g_factor;
  int          g_lat, g_b0, g_v0;
  bit          g_busy_ok, g_frz_ok;

  task automatic abort_run(input string nm);
    chk(nm, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "run aborted: %s", nm);
  endtask

  task automatic run32(input logic [31:0] n, input int hold);
    int budget;
    g_busy_ok = 1;
    g_frz_ok  = 1;
    @(negedge clk);
    budget = 0;
    while (!cand_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!cand_ready) abort_run("cand_ready_timeout");
    g_b0       = bq.size();
    g_v0       = vcnt;
    cand_valid = 1'b1;
    cand_n     = n;
    @(negedge clk);
    cand_valid = 1'b0;
    g_lat      = 1;
    while (!res_valid && g_lat < 3000) begin
      if (cand_ready) g_busy_ok = 0;
      @(negedge clk);
      g_lat++;
    end
    if (!res_valid) abort_run("res_valid_timeout");
    g_prime  = res_prime;
    g_factor = res_factor;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!res_valid || res_prime !== g_prime || res_factor !== g_factor || cand_ready)
        g_frz_ok = 0;
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic run8(input logic [7:0] n, input logic ep, input logic [7:0] ef, input int ntr);
    int  lat;
    int  b0;
    int  d;
    bit  seq_ok;
    @(negedge clk);
    b0          = bq8.size();
    cand8_valid = 1'b1;
    cand8_n     = n;
    @(negedge clk);
    cand8_valid = 1'b0;
    lat         = 1;
    while (!res8_valid && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    if (!res8_valid) abort_run("res8_valid_timeout");
    chk("w8_prime", res8_prime, ep);
    chk("w8_factor", res8_factor, ef);
    chk("w8_ntrials", bq8.size() - b0, ntr);
    seq_ok = 1;
    d      = 2;
    for (int i = 0; i < ntr && b0 + i < bq8.size(); i++) begin
      if (bq8[b0+i] !== 8'(d)) seq_ok = 0;
      d = (d == 2) ? 3 : d + 2;
    end
    chk("w8_bseq_ok", seq_ok, 1);
    res8_ready = 1'b1;
    @(negedge clk);
    res8_ready = 1'b0;
  endtask

  function automatic void ref_model(input logic [31:0] n, output logic p, output logic [31:0] f);
    p = 1'b0;
    f = '0;
    if (n < 2) return;
    for (longint unsigned d = 2; d * d <= 64'(n); d = (d == 2) ? 3 : d + 2) begin
      if (64'(n) % d == 0) begin
        f = 32'(d);
        return;
      end
    end
    p = 1'b1;
  endfunction

  typedef struct {
    logic [31:0] n;
    logic        prime;
    logic [31:0] factor;
    int          ntr;
    int          lat;   // -1: not checked
    int          hold;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic        rp;
    logic [31:0] rf;
    logic [31:0] rn;
    int          rh;
    int          d;
    bit          seq_ok;
    int          budget;

    tbl[0]  = '{32'd0,          1'b0, 32'd0,  0, 2, 0};
    tbl[1]  = '{32'd1,          1'b0, 32'd0,  0, 2, 0};
    tbl[2]  = '{32'd2,          1'b1, 32'd0,  0, 2, 0};
    tbl[3]  = '{32'd3,          1'b1, 32'd0,  0, 2, 5};
    tbl[4]  = '{32'd4,          1'b0, 32'd2,  1, -1, 0};
    tbl[5]  = '{32'd9,          1'b0, 32'd3,  2, -1, 5};
    tbl[6]  = '{32'd97,         1'b1, 32'd0,  5, -1, 5};
    tbl[7]  = '{32'd25,         1'b0, 32'd5,  3, -1, 0};
    tbl[8]  = '{32'd49,         1'b0, 32'd7,  4, -1, 0};
    tbl[9]  = '{32'd91,         1'b0, 32'd7,  4, -1, 0};
    tbl[10] = '{32'd221,        1'b0, 32'd13, 7, -1, 2};
    tbl[11] = '{32'd15,         1'b0, 32'd3,  2, -1, 0};
    tbl[12] = '{32'd65537,      1'b1, 32'd0,  128, -1, 0};
    tbl[13] = '{32'hFFFF_FFFF,  1'b0, 32'd3,  2, -1, 0};
    tbl[14] = '{32'hFFFF_FFFE,  1'b0, 32'd2,  1, -1, 5};

    // reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cand_ready", cand_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_prime", res_prime, 0);
    chk("rst_res_factor", res_factor, 0);
    chk("rst_div_valid", div_valid, 0);
    chk("rst_div_ack", div_ack, 0);
    chk("rst_div_a", div_a, 0);
    chk("rst_div_b", div_b, 0);
    #2 rst_n = 1'b1;

    stall_en = 1;
    noise_en = 1;

    // directed table
    for (int t = 0; t < 15; t++) begin
      run32(tbl[t].n, tbl[t].hold);
      chk($sformatf("tbl%0d_prime", t), g_prime, tbl[t].prime);
      chk($sformatf("tbl%0d_factor", t), g_factor, tbl[t].factor);
      chk($sformatf("tbl%0d_ntrials", t), bq.size() - g_b0, tbl[t].ntr);
      chk($sformatf("tbl%0d_cand_ready_low", t), g_busy_ok, 1);
      seq_ok = 1;
      d      = 2;
      for (int i = 0; i < tbl[t].ntr && g_b0 + i < bq.size(); i++) begin
        if (bq[g_b0+i] !== 32'(d)) seq_ok = 0;
        d = (d == 2) ? 3 : d + 2;
      end
      chk($sformatf("tbl%0d_bseq_ok", t), seq_ok, 1);
      if (tbl[t].lat >= 0) chk($sformatf("tbl%0d_latency", t), g_lat, tbl[t].lat);
      if (tbl[t].ntr == 0) chk($sformatf("tbl%0d_no_div_valid", t), vcnt - g_v0, 0);
      if (tbl[t].hold > 0) chk($sformatf("tbl%0d_frozen", t), g_frz_ok, 1);
    end

    // 8-bit instance: d*d must not wrap at WIDTH bits
    run8(8'd255, 1'b0, 8'd3, 2);
    run8(8'd251, 1'b1, 8'd0, 8);

    // reset in the middle of WAIT, then a fresh candidate
    @(negedge clk);
    cand_valid = 1'b1;
    cand_n     = 32'd97;
    @(negedge clk);
    cand_valid = 1'b0;
    budget     = 0;
    while (!div_ack && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk("mid_wait_reached", div_ack, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cand_ready", cand_ready, 1);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_prime", res_prime, 0);
    chk("mid_rst_res_factor", res_factor, 0);
    chk("mid_rst_div_valid", div_valid, 0);
    chk("mid_rst_div_ack", div_ack, 0);
    chk("mid_rst_div_a", div_a, 0);
    chk("mid_rst_div_b", div_b, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run32(32'd4, 0);
    chk("post_rst_prime", g_prime, 0);
    chk("post_rst_factor", g_factor, 2);

    // random candidates against the reference model
    for (int r = 0; r < 1000; r++) begin
      rn = 32'($urandom_range(0, 400));
      rh = ($urandom_range(0, 9) == 0) ? 5 : 0;
      run32(rn, rh);
      ref_model(rn, rp, rf);
      chk($sformatf("rand_prime_n%0d", rn), g_prime, rp);
      chk($sformatf("rand_factor_n%0d", rn), g_factor, rf);
      if (!g_busy_ok) chk($sformatf("rand_cand_ready_low_n%0d", rn), g_busy_ok, 1);
      if (!g_frz_ok) chk($sformatf("rand_frozen_n%0d", rn), g_frz_ok, 1);
    end

    chk("div_operands_stable", stab_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
